// File: rtl/cpu_host_loader_pkg.sv
// Shared types and constants for the host-side cpu image loader / memory dumper.
package cpu_host_loader_pkg;
    localparam int IMEM_DEPTH = 64;
    localparam int DMEM_DEPTH = 128;
    localparam int ADDR_STEP  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DUMP,
        ST_DONE
    } state_t;

    function automatic logic [15:0] clamp_len(input logic [15:0] len, input logic [15:0] max_len);
        return (len > max_len) ? max_len : len;
    endfunction

    function automatic logic [63:0] word_addr(input logic [15:0] idx);
        return 64'(idx) * 64'(ADDR_STEP);
    endfunction
endpackage

// File: rtl/host_loader_fifo2.sv
// Two-entry 64-bit FIFO holding data-memory words on their way to the dump stream.
// Combinational head output; push into a full FIFO is accepted when a pop happens the same cycle.
module host_loader_fifo2 (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        push,
    input  logic [63:0] din,
    input  logic        pop,
    output logic [63:0] dout,
    output logic        full,
    output logic        empty
);
    logic [63:0] r_mem [2];
    logic        r_wp;
    logic        r_rp;
    logic [1:0]  r_cnt;
    logic        w_push_ok;
    logic        w_pop_ok;

    assign w_pop_ok  = pop && (r_cnt != 2'd0);
    assign w_push_ok = push && ((r_cnt != 2'd2) || w_pop_ok);
    assign dout      = r_mem[r_rp];
    assign full      = (r_cnt == 2'd2);
    assign empty     = (r_cnt == 2'd0);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wp     <= 1'b0;
            r_rp     <= 1'b0;
            r_cnt    <= 2'd0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wp] <= din;
                r_wp        <= ~r_wp;
            end
            if (w_pop_ok) begin
                r_rp <= ~r_rp;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end
endmodule

// File: rtl/cpu_host_loader.sv
// Loads a program image into cpu IMEM, runs the cpu for a fixed budget, then streams DMEM out.
// Reads are only issued while FIFO occupancy plus the in-flight read stays below two entries.
module cpu_host_loader
    import cpu_host_loader_pkg::*;
(
    input  logic        clk,
    input  logic        arst_n,
    input  logic        start,
    input  logic [15:0] imem_len,
    input  logic [15:0] dmem_len,
    input  logic [31:0] run_cycles,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [63:0] s_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [63:0] m_data,
    output logic        cpu_enable,
    output logic [63:0] addr_ext,
    output logic [63:0] wdata_ext,
    output logic        wen_ext,
    output logic        ren_ext,
    input  logic [63:0] rdata_ext,
    output logic [63:0] addr_ext_2,
    output logic [63:0] wdata_ext_2,
    output logic        wen_ext_2,
    output logic        ren_ext_2,
    input  logic [63:0] rdata_ext_2,
    output logic        busy,
    output logic        done
);
    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_imem_len;
    logic [15:0] r_dmem_len;
    logic [31:0] r_run_cycles;
    logic [15:0] r_wr_idx;
    logic [15:0] r_rd_idx;
    logic [31:0] r_run_cnt;
    logic        r_inflight;
    logic [15:0] w_imem_clamp;
    logic [15:0] w_dmem_clamp;
    logic        w_beat;
    logic        w_issue;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    logic [1:0]  w_occ;
    logic        w_unused_rdata;

    // The IMEM read-back path is reserved and never consumed.
    assign w_unused_rdata = ^rdata_ext;

    assign w_imem_clamp = clamp_len(imem_len, 16'(IMEM_DEPTH));
    assign w_dmem_clamp = clamp_len(dmem_len, 16'(DMEM_DEPTH));
    assign w_beat       = (r_state == ST_LOAD) && s_valid;
    assign w_occ        = w_full ? 2'd2 : (w_empty ? 2'd0 : 2'd1);
    assign w_issue      = (r_state == ST_DUMP) && (r_rd_idx != r_dmem_len)
                          && ((w_occ + {1'b0, r_inflight}) < 2'd2);
    assign m_valid      = !w_empty;
    assign w_pop        = m_valid && m_ready;

    always_comb begin
        w_next      = r_state;
        s_ready     = 1'b0;
        wen_ext     = 1'b0;
        wdata_ext   = '0;
        addr_ext    = '0;
        ren_ext     = 1'b0;
        cpu_enable  = 1'b0;
        ren_ext_2   = 1'b0;
        addr_ext_2  = '0;
        wen_ext_2   = 1'b0;
        wdata_ext_2 = '0;
        busy        = (r_state != ST_IDLE);
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (w_imem_clamp != 16'd0)     w_next = ST_LOAD;
                    else if (run_cycles != 32'd0)  w_next = ST_RUN;
                    else if (w_dmem_clamp != 16'd0) w_next = ST_DUMP;
                    else                            w_next = ST_DONE;
                end
            end
            ST_LOAD: begin
                s_ready   = 1'b1;
                wen_ext   = w_beat;
                wdata_ext = w_beat ? s_data : 64'd0;
                addr_ext  = word_addr(r_wr_idx);
                if (w_beat && (r_wr_idx == r_imem_len - 16'd1)) begin
                    if (r_run_cycles != 32'd0)     w_next = ST_RUN;
                    else if (r_dmem_len != 16'd0)  w_next = ST_DUMP;
                    else                           w_next = ST_DONE;
                end
            end
            ST_RUN: begin
                cpu_enable = 1'b1;
                if (r_run_cnt == r_run_cycles - 32'd1) begin
                    w_next = (r_dmem_len != 16'd0) ? ST_DUMP : ST_DONE;
                end
            end
            ST_DUMP: begin
                ren_ext_2  = w_issue;
                addr_ext_2 = word_addr(r_rd_idx);
                if ((r_rd_idx == r_dmem_len) && !r_inflight && w_empty) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state      <= ST_IDLE;
            r_imem_len   <= '0;
            r_dmem_len   <= '0;
            r_run_cycles <= '0;
            r_wr_idx     <= '0;
            r_rd_idx     <= '0;
            r_run_cnt    <= '0;
            r_inflight   <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_inflight <= w_issue;
            // Each counter is used by a single phase, so clearing them once per session suffices.
            if ((r_state == ST_IDLE) && start) begin
                r_imem_len   <= w_imem_clamp;
                r_dmem_len   <= w_dmem_clamp;
                r_run_cycles <= run_cycles;
                r_wr_idx     <= '0;
                r_rd_idx     <= '0;
                r_run_cnt    <= '0;
            end
            if (w_beat) r_wr_idx <= r_wr_idx + 16'd1;
            if (r_state == ST_RUN) r_run_cnt <= r_run_cnt + 32'd1;
            if (w_issue) r_rd_idx <= r_rd_idx + 16'd1;
        end
    end

    host_loader_fifo2 u_fifo (
        .clk    (clk),
        .arst_n (arst_n),
        .push   (r_inflight),
        .din    (rdata_ext_2),
        .pop    (w_pop),
        .dout   (m_data),
        .full   (w_full),
        .empty  (w_empty)
    );
endmodule

// File: tb/tb_cpu_host_loader.sv
// Directed bench for cpu_host_loader with an IMEM write / DMEM dump scoreboard.
module tb_cpu_host_loader;
    logic        clk = 1'b0;
    logic        arst_n;
    logic        start;
    logic [15:0] imem_len;
    logic [15:0] dmem_len;
    logic [31:0] run_cycles;
    logic        s_valid;
    logic        s_ready;
    logic [63:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [63:0] m_data;
    logic        cpu_enable;
    logic [63:0] addr_ext;
    logic [63:0] wdata_ext;
    logic        wen_ext;
    logic        ren_ext;
    logic [63:0] rdata_ext;
    logic [63:0] addr_ext_2;
    logic [63:0] wdata_ext_2;
    logic        wen_ext_2;
    logic        ren_ext_2;
    logic [63:0] rdata_ext_2;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    cpu_host_loader dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .start       (start),
        .imem_len    (imem_len),
        .dmem_len    (dmem_len),
        .run_cycles  (run_cycles),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .cpu_enable  (cpu_enable),
        .addr_ext    (addr_ext),
        .wdata_ext   (wdata_ext),
        .wen_ext     (wen_ext),
        .ren_ext     (ren_ext),
        .rdata_ext   (rdata_ext),
        .addr_ext_2  (addr_ext_2),
        .wdata_ext_2 (wdata_ext_2),
        .wen_ext_2   (wen_ext_2),
        .ren_ext_2   (ren_ext_2),
        .rdata_ext_2 (rdata_ext_2),
        .busy        (busy),
        .done        (done)
    );

    // DMEM model: one-cycle read latency
    logic [63:0] dmem [0:255];
    always @(posedge clk) begin
        rdata_ext_2 <= dmem[addr_ext_2[10:3]];
    end

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] obs_wa[$];
    logic [63:0] obs_wd[$];
    logic [63:0] obs_m[$];
    logic [63:0] exp_wa[$];
    logic [63:0] exp_wd[$];
    logic [63:0] exp_m[$];
    int   en_cycles, run_viol, wr_viol, ovr, done_cnt, done_long, pend;
    logic prev_done;

    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            pend      = 0;
            prev_done = 1'b0;
        end else begin
            if (wen_ext) begin
                obs_wa.push_back(addr_ext);
                obs_wd.push_back(wdata_ext);
                if (!(s_valid && s_ready)) wr_viol++;
            end
            if (m_valid && m_ready) obs_m.push_back(m_data);
            if (cpu_enable) begin
                en_cycles++;
                if (wen_ext || ren_ext || wen_ext_2 || ren_ext_2 || s_ready || m_valid) run_viol++;
            end
            pend = pend + (ren_ext_2 ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
            if (pend > 2) ovr++;
            if (done) begin
                done_cnt++;
                if (prev_done) done_long++;
            end
            prev_done = done;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic start_session(input int il, input int dl, input int rc, input logic [63:0] dbase, input bit rnd);
        int n;
        @(negedge clk);
        obs_wa.delete(); obs_wd.delete(); obs_m.delete();
        exp_wa.delete(); exp_wd.delete(); exp_m.delete();
        en_cycles = 0; run_viol = 0; wr_viol = 0; ovr = 0; done_cnt = 0; done_long = 0;
        n = (dl > 128) ? 128 : dl;
        for (int j = 0; j < 256; j++) dmem[j] = rnd ? {$urandom, $urandom} : dbase + 64'(j);
        for (int j = 0; j < n; j++) exp_m.push_back(dmem[j]);
        imem_len = 16'(il); dmem_len = 16'(dl); run_cycles = 32'(rc);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic load_image(input int n, input bit toggle, input logic [63:0] base);
        int  k = 0;
        int  cyc = 0;
        bit  beat;
        while (k < n && cyc < 1000) begin
            s_valid = toggle ? ((cyc % 2) == 0) : 1'b1;
            s_data  = base + 64'(k);
            beat    = s_valid && s_ready;
            if (beat) begin
                exp_wa.push_back(64'(k) * 64'd8);
                exp_wd.push_back(s_data);
            end
            @(negedge clk);
            if (beat) k++;
            cyc++;
        end
        s_valid = 1'b0;
        chk("load_budget", 64'(k), 64'(n));
    endtask

    task automatic wait_done(input int pct);
        int cyc = 0;
        while (done_cnt == 0 && cyc < 3000) begin
            m_ready = ($urandom_range(0, 99) < pct);
            @(negedge clk);
            cyc++;
        end
        m_ready = 1'b0;
        chk("done_seen", 64'(done_cnt), 64'd1);
        @(negedge clk);
        chk("done_single_cycle", 64'(done_long), 64'd0);
        chk("idle_after_done", {63'd0, busy}, 64'd0);
    endtask

    task automatic check_scoreboard(input string tag, input int rc);
        chk({tag, "_wr_count"}, 64'(obs_wa.size()), 64'(exp_wa.size()));
        while (exp_wa.size() > 0 && obs_wa.size() > 0) begin
            chk({tag, "_wr_addr"}, obs_wa.pop_front(), exp_wa.pop_front());
            chk({tag, "_wr_data"}, obs_wd.pop_front(), exp_wd.pop_front());
        end
        chk({tag, "_wr_no_beat"}, 64'(wr_viol), 64'd0);
        chk({tag, "_run_cycles"}, 64'(en_cycles), 64'(rc));
        chk({tag, "_run_idle_ports"}, 64'(run_viol), 64'd0);
        chk({tag, "_dump_count"}, 64'(obs_m.size()), 64'(exp_m.size()));
        while (exp_m.size() > 0 && obs_m.size() > 0) begin
            chk({tag, "_dump_word"}, obs_m.pop_front(), exp_m.pop_front());
        end
        chk({tag, "_fifo_overrun"}, 64'(ovr), 64'd0);
    endtask

    initial begin
        int cyc;
        arst_n = 1'b1; start = 1'b0; imem_len = '0; dmem_len = '0; run_cycles = '0;
        s_valid = 1'b0; s_data = '0; m_ready = 1'b0; rdata_ext = '0;
        en_cycles = 0; run_viol = 0; wr_viol = 0; ovr = 0; done_cnt = 0; done_long = 0;
        for (int j = 0; j < 256; j++) dmem[j] = '0;
        #2 arst_n = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("rst_ctrl", {56'd0, busy, done, cpu_enable, s_ready, m_valid, wen_ext, ren_ext_2, wen_ext_2}, 64'd0);
        chk("rst_addr_ext", addr_ext, 64'd0);
        chk("rst_addr_ext_2", addr_ext_2, 64'd0);
        arst_n = 1'b1;

        // held s_valid, 5-cycle run, DMEM 10..13 with m_ready always high; stray start while busy
        start_session(3, 4, 5, 64'd10, 1'b0);
        load_image(3, 1'b0, 64'hA0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(100);
        check_scoreboard("s1", 5);

        // toggled s_valid, random 30% m_ready, random DMEM contents
        start_session(3, 4, 2, 64'd0, 1'b1);
        load_image(3, 1'b1, 64'hB0);
        wait_done(30);
        check_scoreboard("s2", 2);

        // all lengths zero: straight to DONE
        start_session(0, 0, 0, 64'd0, 1'b0);
        wait_done(100);
        check_scoreboard("s3", 0);

        // oversize lengths clamp to the memory depths
        start_session(70, 200, 1, 64'h1000, 1'b0);
        load_image(64, 1'b0, 64'hC00);
        wait_done(60);
        check_scoreboard("s4", 1);

        // reset while dumping, then a clean session
        start_session(2, 4, 3, 64'h200, 1'b0);
        load_image(2, 1'b0, 64'hD0);
        cyc = 0;
        while (obs_m.size() < 2 && cyc < 200) begin
            m_ready = 1'b1;
            @(negedge clk);
            cyc++;
        end
        chk("s5_reached_dump", 64'(obs_m.size()), 64'd2);
        m_ready = 1'b0;
        arst_n  = 1'b0;
        #1;
        chk("s5_rst_ctrl", {56'd0, busy, done, cpu_enable, s_ready, m_valid, wen_ext, ren_ext_2, wen_ext_2}, 64'd0);
        chk("s5_rst_addr_ext_2", addr_ext_2, 64'd0);
        chk("s5_rst_m_data", m_data, 64'd0);
        @(negedge clk);
        arst_n = 1'b1;
        start_session(2, 4, 3, 64'h300, 1'b0);
        load_image(2, 1'b0, 64'hE0);
        wait_done(50);
        check_scoreboard("s6", 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
